// File: rtl/sd_data_master.sv
// SD card data-path control FSM. It primes the TX/RX FIFOs and kicks the serial host.
// It then watches the transfer (watchdog, FIFO errors) and records the outcome in sticky status bits.
module sd_data_master #(
    parameter int TIMEOUT_W     = 24,
    parameter int INT_DATA_SIZE = 5
) (
    input  logic                     sd_clk,
    input  logic                     rst,
    input  logic                     start_tx_i,
    input  logic                     start_rx_i,
    input  logic [TIMEOUT_W-1:0]     timeout_i,
    output logic                     d_write_o,
    output logic                     d_read_o,
    output logic                     start_tx_fifo_o,
    output logic                     start_rx_fifo_o,
    input  logic                     tx_fifo_empty_i,
    input  logic                     tx_fifo_full_i,
    input  logic                     rx_fifo_full_i,
    input  logic                     xfr_complete_i,
    input  logic                     crc_ok_i,
    output logic [INT_DATA_SIZE-1:0] int_status_o,
    input  logic                     int_status_rst_i
);

    localparam int CC    = 0;
    localparam int EI    = 1;
    localparam int CTE   = 2;
    localparam int CCRCE = 3;
    localparam int CFE   = 4;

    typedef enum logic [2:0] {
        IDLE,
        START_TX_FIFO,
        START_RX_FIFO,
        DATA_TRANSFER,
        ABORT
    } state_t;

    state_t                   r_state,    w_state;
    logic                     r_d_write,  w_d_write;
    logic                     r_d_read,   w_d_read;
    logic                     r_tx_fifo,  w_tx_fifo;
    logic                     r_rx_fifo,  w_rx_fifo;
    logic                     r_is_tx,    w_is_tx;
    logic [TIMEOUT_W-1:0]     r_cnt,      w_cnt;
    logic [INT_DATA_SIZE-1:0] r_status;
    logic [INT_DATA_SIZE-1:0] w_set;
    logic                     w_timeout;
    logic                     w_fifo_err;

    // The watchdog is disabled by a zero limit; the counter saturates so a long
    // unsupervised transfer cannot wrap it.
    assign w_timeout  = (timeout_i != '0) && (r_cnt >= timeout_i);
    assign w_fifo_err = r_is_tx ? tx_fifo_empty_i : rx_fifo_full_i;

    always_comb begin
        w_state   = r_state;
        w_d_write = r_d_write;
        w_d_read  = r_d_read;
        w_tx_fifo = r_tx_fifo;
        w_rx_fifo = r_rx_fifo;
        w_is_tx   = r_is_tx;
        w_cnt     = '0;
        w_set     = '0;
        case (r_state)
            IDLE: begin
                if (start_tx_i) begin
                    w_state   = START_TX_FIFO;
                    w_tx_fifo = 1'b1;
                    w_is_tx   = 1'b1;
                end else if (start_rx_i) begin
                    w_state   = START_RX_FIFO;
                    w_rx_fifo = 1'b1;
                    w_is_tx   = 1'b0;
                end
            end
            START_TX_FIFO: begin
                w_d_read = 1'b0;
                if (tx_fifo_full_i && xfr_complete_i) begin
                    w_d_write = 1'b1;
                end else if (r_d_write && !xfr_complete_i) begin
                    w_d_write = 1'b0;
                    w_state   = DATA_TRANSFER;
                end
            end
            START_RX_FIFO: begin
                w_d_write = 1'b0;
                if (xfr_complete_i) begin
                    w_d_read = 1'b1;
                end else begin
                    w_d_read = 1'b0;
                    w_state  = DATA_TRANSFER;
                end
            end
            DATA_TRANSFER: begin
                w_cnt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
                if (w_timeout || w_fifo_err) begin
                    if (w_timeout) begin
                        w_set[CTE] = 1'b1;
                    end else begin
                        w_set[CFE] = 1'b1;
                    end
                    w_set[EI] = 1'b1;
                    w_state   = ABORT;
                    w_d_write = 1'b1;
                    w_d_read  = 1'b1;
                    w_tx_fifo = 1'b0;
                    w_rx_fifo = 1'b0;
                end else if (xfr_complete_i) begin
                    if (crc_ok_i) begin
                        w_set[CC] = 1'b1;
                    end else begin
                        w_set[CCRCE] = 1'b1;
                        w_set[EI]    = 1'b1;
                    end
                    w_state   = IDLE;
                    w_tx_fifo = 1'b0;
                    w_rx_fifo = 1'b0;
                end
            end
            ABORT: begin
                // Both commands high tell the serial host to abort; release once it is idle.
                w_d_write = 1'b1;
                w_d_read  = 1'b1;
                w_tx_fifo = 1'b0;
                w_rx_fifo = 1'b0;
                if (xfr_complete_i) begin
                    w_d_write = 1'b0;
                    w_d_read  = 1'b0;
                    w_state   = IDLE;
                end
            end
            default: begin
                w_state   = IDLE;
                w_d_write = 1'b0;
                w_d_read  = 1'b0;
                w_tx_fifo = 1'b0;
                w_rx_fifo = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sd_clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_d_write <= 1'b0;
            r_d_read  <= 1'b0;
            r_tx_fifo <= 1'b0;
            r_rx_fifo <= 1'b0;
            r_is_tx   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state;
            r_d_write <= w_d_write;
            r_d_read  <= w_d_read;
            r_tx_fifo <= w_tx_fifo;
            r_rx_fifo <= w_rx_fifo;
            r_is_tx   <= w_is_tx;
            r_cnt     <= w_cnt;
        end
    end

    // Clear wins over any status bit being set in the same cycle.
    always_ff @(posedge sd_clk) begin
        if (!rst) begin
            r_status <= '0;
        end else if (int_status_rst_i) begin
            r_status <= '0;
        end else begin
            r_status <= r_status | w_set;
        end
    end

    assign d_write_o       = r_d_write;
    assign d_read_o        = r_d_read;
    assign start_tx_fifo_o = r_tx_fifo;
    assign start_rx_fifo_o = r_rx_fifo;
    assign int_status_o    = r_status;

endmodule

// File: tb/tb_sd_data_master.sv
// Self-checking bench for sd_data_master: directed scenarios plus randomized transfers.
// Expected status comes from a sticky-OR model of transfer outcomes.
module tb_sd_data_master;
    localparam int TW = 24;

    logic          sd_clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_tx_i = 1'b0;
    logic          start_rx_i = 1'b0;
    logic [TW-1:0] timeout_i = 24'd100;
    logic          d_write_o, d_read_o, start_tx_fifo_o, start_rx_fifo_o;
    logic          tx_fifo_empty_i = 1'b0;
    logic          tx_fifo_full_i = 1'b0;
    logic          rx_fifo_full_i = 1'b0;
    logic          xfr_complete_i = 1'b1;
    logic          crc_ok_i = 1'b0;
    logic [4:0]    int_status_o;
    logic          int_status_rst_i = 1'b0;

    int            checks = 0;
    int            errors = 0;
    logic [4:0]    m_status = 5'h00;

    sd_data_master #(.TIMEOUT_W(TW), .INT_DATA_SIZE(5)) dut (
        .sd_clk          (sd_clk),
        .rst             (rst),
        .start_tx_i      (start_tx_i),
        .start_rx_i      (start_rx_i),
        .timeout_i       (timeout_i),
        .d_write_o       (d_write_o),
        .d_read_o        (d_read_o),
        .start_tx_fifo_o (start_tx_fifo_o),
        .start_rx_fifo_o (start_rx_fifo_o),
        .tx_fifo_empty_i (tx_fifo_empty_i),
        .tx_fifo_full_i  (tx_fifo_full_i),
        .rx_fifo_full_i  (rx_fifo_full_i),
        .xfr_complete_i  (xfr_complete_i),
        .crc_ok_i        (crc_ok_i),
        .int_status_o    (int_status_o),
        .int_status_rst_i(int_status_rst_i)
    );

    always #5 sd_clk = ~sd_clk;

    // Outcome kinds: 0 good CRC, 1 bad CRC, 2 FIFO error, 3 watchdog timeout.
    function automatic logic [4:0] code_of(input int outc);
        case (outc)
            0:       return 5'h01;
            1:       return 5'h0A;
            2:       return 5'h12;
            default: return 5'h06;
        endcase
    endfunction

    task automatic step();
        @(posedge sd_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input bit wr, input bit rd, input bit txf, input bit rxf);
        chk(tag, {28'd0, d_write_o, d_read_o, start_tx_fifo_o, start_rx_fifo_o},
                 {28'd0, wr, rd, txf, rxf});
    endtask

    task automatic chk_st(input string tag);
        chk(tag, {27'd0, int_status_o}, {27'd0, m_status});
    endtask

    task automatic clear_status();
        int_status_rst_i = 1'b1;
        step();
        int_status_rst_i = 1'b0;
        m_status = 5'h00;
        chk_st("clear");
    endtask

    task automatic txn(input bit is_tx, input int outc, input int busy, input int tmo,
                       input bit both, input bit clr_same);
        int n;
        bit seen;
        timeout_i      = TW'(tmo);
        xfr_complete_i = 1'b1;
        crc_ok_i       = 1'b0;
        start_tx_i     = is_tx;
        start_rx_i     = !is_tx || both;
        step();
        start_tx_i = 1'b0;
        start_rx_i = 1'b0;
        chk_out("start", 0, 0, is_tx, !is_tx);

        if (is_tx) begin
            repeat ($urandom_range(0, 2)) begin
                step();
                chk_out("prime_wait", 0, 0, 1, 0);
            end
            tx_fifo_full_i = 1'b1;
            step();
            chk_out("prime_full", 1, 0, 1, 0);
            repeat ($urandom_range(0, 2)) begin
                step();
                chk_out("wr_hold", 1, 0, 1, 0);
            end
            xfr_complete_i = 1'b0;
            step();
            chk_out("wr_drop", 0, 0, 1, 0);
            tx_fifo_full_i = 1'b0;
        end else begin
            step();
            chk_out("rd_go", 0, 1, 0, 1);
            repeat ($urandom_range(0, 2)) begin
                step();
                chk_out("rd_hold", 0, 1, 0, 1);
            end
            xfr_complete_i = 1'b0;
            step();
            chk_out("rd_drop", 0, 0, 0, 1);
        end

        if (outc <= 1) begin
            repeat (busy) begin
                start_tx_i = 1'($urandom_range(0, 1));
                start_rx_i = 1'($urandom_range(0, 1));
                step();
                chk_out("busy", 0, 0, is_tx, !is_tx);
            end
            start_tx_i       = 1'b0;
            start_rx_i       = 1'b0;
            xfr_complete_i   = 1'b1;
            crc_ok_i         = (outc == 0);
            int_status_rst_i = clr_same;
            step();
            int_status_rst_i = 1'b0;
            m_status = clr_same ? 5'h00 : (m_status | code_of(outc));
            chk_out("done", 0, 0, 0, 0);
            chk_st("done_status");
        end else if (outc == 2) begin
            repeat (busy) begin
                step();
                chk_out("busy", 0, 0, is_tx, !is_tx);
            end
            if (is_tx) tx_fifo_empty_i = 1'b1;
            else       rx_fifo_full_i  = 1'b1;
            step();
            tx_fifo_empty_i = 1'b0;
            rx_fifo_full_i  = 1'b0;
            m_status = m_status | code_of(2);
            chk_out("fifo_abort", 1, 1, 0, 0);
            chk_st("fifo_status");
            repeat ($urandom_range(0, 3)) begin
                step();
                chk_out("abort_hold", 1, 1, 0, 0);
            end
            xfr_complete_i = 1'b1;
            step();
            chk_out("abort_end", 0, 0, 0, 0);
        end else begin
            n = 0;
            seen = 1'b0;
            while (!seen && n < tmo + 50) begin
                step();
                n++;
                if (d_write_o && d_read_o) seen = 1'b1;
            end
            // The counter reads 0 in the first busy cycle, so the abort lands tmo+1 edges in.
            chk("tmo_cycles", 32'(n), 32'(tmo + 1));
            m_status = m_status | code_of(3);
            chk_out("tmo_abort", 1, 1, 0, 0);
            chk_st("tmo_status");
            xfr_complete_i = 1'b1;
            step();
            chk_out("tmo_end", 0, 0, 0, 0);
        end
        chk_st("idle_status");
    endtask

    initial begin
        int outc, busy, tmo;
        bit is_tx;

        rst = 1'b0;
        repeat (3) begin
            step();
            chk_out("in_reset", 0, 0, 0, 0);
            chk_st("in_reset_status");
        end
        rst = 1'b1;
        repeat (3) begin
            step();
            chk_out("post_reset", 0, 0, 0, 0);
            chk_st("post_reset_status");
        end

        txn(1, 0, 10, 100, 0, 0);
        clear_status();
        txn(0, 0, 10, 100, 0, 0);
        clear_status();
        txn(0, 1, 10, 100, 0, 0);
        clear_status();
        txn(1, 1, 10, 100, 0, 0);
        clear_status();
        txn(1, 2, 3, 100, 0, 0);
        clear_status();
        txn(0, 2, 3, 100, 0, 0);
        clear_status();
        txn(1, 3, 0, 100, 0, 0);
        clear_status();
        txn(0, 3, 0, 100, 0, 0);
        clear_status();
        txn(1, 0, 5, 100, 0, 0);
        txn(1, 0, 5, 100, 0, 1);
        txn(1, 0, 4, 100, 1, 0);
        txn(0, 0, 30, 0, 0, 0);
        txn(0, 1, 2, 100, 0, 0);

        repeat (40) begin
            is_tx = 1'($urandom_range(0, 1));
            outc  = int'($urandom_range(0, 3));
            busy  = int'($urandom_range(0, 15));
            if (outc == 3)                    tmo = int'($urandom_range(1, 30));
            else if ($urandom_range(0, 3) == 0) tmo = 0;
            else                              tmo = busy + 1 + int'($urandom_range(0, 20));
            txn(is_tx, outc, busy, tmo, 1'($urandom_range(0, 1)),
                (outc <= 1) && ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) clear_status();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
